// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB LED PWM generator with prescaler, frame-synchronous duty shadowing
// and an optional on/off blink sequencer counted in whole PWM frames.
module rgb_pwm_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [2:0] rgb_pwm,
  output logic       rgbled_en,
  output logic       frame_sync
);

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StRunOn  = 2'd1,
    StRunOff = 2'd2
  } state_e;

  localparam logic [2:0] AddrDuty0 = 3'd0;
  localparam logic [2:0] AddrDuty1 = 3'd1;
  localparam logic [2:0] AddrDuty2 = 3'd2;
  localparam logic [2:0] AddrPre   = 3'd3;
  localparam logic [2:0] AddrOnT   = 3'd4;
  localparam logic [2:0] AddrOffT  = 3'd5;

  state_e r_state;
  state_e w_state_d;

  logic [2:0][7:0] r_duty;
  logic [2:0][7:0] r_shadow;
  logic [7:0]      r_pre;
  logic [7:0]      r_on_t;
  logic [7:0]      r_off_t;

  logic [7:0] r_pre_cnt;
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_frame_cnt;

  logic [2:0] r_rgb_pwm;
  logic       r_rgbled_en;

  logic       w_run;
  logic       w_start;
  logic       w_tick;
  logic       w_frame_end;
  logic       w_blink;
  logic       w_on_done;
  logic       w_off_done;
  logic [8:0] w_frames_done;
  logic [2:0] w_pwm_d;
  logic       w_rgbled_d;

  assign w_run       = (r_state != StOff);
  assign w_start     = (r_state == StOff) && led_en;
  // >= keeps the prescaler from a full wrap if pre is lowered below the running count
  assign w_tick      = w_run && (r_pre_cnt >= r_pre);
  assign w_frame_end = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_blink     = (r_on_t != 8'd0) && (r_off_t != 8'd0);

  // Frames completed including the one ending now; >= tolerates on_t/off_t lowered mid-phase.
  assign w_frames_done = {1'b0, r_frame_cnt} + 9'd1;
  assign w_on_done     = (w_frames_done >= {1'b0, r_on_t});
  assign w_off_done    = (w_frames_done >= {1'b0, r_off_t});

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty  <= '0;
      r_pre   <= 8'd0;
      r_on_t  <= 8'd0;
      r_off_t <= 8'd0;
    end else if (wr_en) begin
      case (wr_addr)
        AddrDuty0: r_duty[0] <= wr_data;
        AddrDuty1: r_duty[1] <= wr_data;
        AddrDuty2: r_duty[2] <= wr_data;
        AddrPre:   r_pre     <= wr_data;
        AddrOnT:   r_on_t    <= wr_data;
        AddrOffT:  r_off_t   <= wr_data;
        default: ;
      endcase
    end
  end

  // Shadow copy reads r_duty before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_start || w_frame_end) begin
      r_shadow <= r_duty;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StOff;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state; led_en=0 outranks any frame-end transition
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StOff: begin
        if (led_en) w_state_d = StRunOn;
      end
      StRunOn: begin
        if (!led_en) begin
          w_state_d = StOff;
        end else if (w_frame_end && w_blink && w_on_done) begin
          w_state_d = StRunOff;
        end
      end
      StRunOff: begin
        if (!led_en) begin
          w_state_d = StOff;
        end else if (w_frame_end && (!w_blink || w_off_done)) begin
          w_state_d = StRunOn;
        end
      end
      default: w_state_d = StOff;
    endcase
  end

  // FSM: output decode (registered below)
  always_comb begin
    w_pwm_d    = 3'b000;
    w_rgbled_d = w_run;
    for (int i = 0; i < 3; i++) begin
      if ((r_state == StRunOn) && (r_pwm_cnt < r_shadow[i])) begin
        w_pwm_d[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, PWM and frame counters; held at zero whenever OFF is current or next
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt   <= 8'd0;
      r_pwm_cnt   <= 8'd0;
      r_frame_cnt <= 8'd0;
    end else if ((r_state == StOff) || (w_state_d == StOff)) begin
      r_pre_cnt   <= 8'd0;
      r_pwm_cnt   <= 8'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_tick) begin
        r_pre_cnt <= 8'd0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_pre_cnt <= r_pre_cnt + 8'd1;
      end
      if (w_frame_end) begin
        r_frame_cnt <= (w_state_d != r_state) ? 8'd0 : r_frame_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_pwm   <= 3'b000;
      r_rgbled_en <= 1'b0;
    end else begin
      r_rgb_pwm   <= w_pwm_d;
      r_rgbled_en <= w_rgbled_d;
    end
  end

  assign rgb_pwm    = r_rgb_pwm;
  assign rgbled_en  = r_rgbled_en;
  assign frame_sync = w_frame_end;

endmodule
